el2_pmp_csr: RTL and testbench

PMP configuration CSR file sitting directly upstream of the PMP checker. It decodes CSR reads and writes to pmpcfg*, pmpaddr* and (optionally) mseccfg, enforces lock and WARL rules, and drives the registered pmpcfg/pmpaddr/mseccfg state that the checker consumes every cycle. Writes commit on the next clock edge. Reads return data one cycle later.

---
 rtl/el2_pmp_csr_if.sv | 22 ++
 rtl/el2_pmp_csr.sv | 211 +++++++++++++++++++++
 tb/tb_el2_pmp_csr.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/el2_pmp_csr_if.sv
// CSR access port of the PMP configuration register file.
// The master issues single-cycle writes and reads; the slave answers reads one cycle later.
interface el2_pmp_csr_if;
  logic        csr_wr_en;
  logic [11:0] csr_wr_addr;
  logic [31:0] csr_wr_data;
  logic        csr_rd_en;
  logic [11:0] csr_rd_addr;
  logic        csr_rd_valid;
  logic        csr_rd_hit;
  logic [31:0] csr_rd_data;

  modport master (
    output csr_wr_en, csr_wr_addr, csr_wr_data, csr_rd_en, csr_rd_addr,
    input  csr_rd_valid, csr_rd_hit, csr_rd_data
  );

  modport slave (
    input  csr_wr_en, csr_wr_addr, csr_wr_data, csr_rd_en, csr_rd_addr,
    output csr_rd_valid, csr_rd_hit, csr_rd_data
  );
endinterface

// File: rtl/el2_pmp_csr.sv
// PMP configuration CSR file: pmpcfg0..3 (0x3A0..0x3A3), pmpaddr0..15 (0x3B0..0x3BF) and,
// when RV_SMEPMP_MSECCFG_EN is defined, mseccfg (0x747). Applies lock and WARL rules and
// exposes the registered state to the PMP checker.
package el2_pmp_csr_pkg;
  typedef enum logic [1:0] {
    ModeOff   = 2'b00,
    ModeTor   = 2'b01,
    ModeNa4   = 2'b10,
    ModeNapot = 2'b11
  } el2_pmp_mode_t;

  typedef struct packed {
    logic          lock;
    logic [1:0]    reserved;
    el2_pmp_mode_t mode;
    logic          execute;
    logic          write;
    logic          read;
  } el2_pmp_cfg_pkt_t;

  typedef struct packed {
    logic rlb;
    logic mmwp;
    logic mml;
  } el2_mseccfg_pkt_t;
endpackage

module el2_pmp_csr
  import el2_pmp_csr_pkg::*;
#(
  parameter int unsigned PMP_ENTRIES     = 16,
  parameter int unsigned PMP_GRANULARITY = 0
) (
  input  logic             clk,
  input  logic             rst_l,
  el2_pmp_csr_if.slave     csr,
  output el2_pmp_cfg_pkt_t pmp_pmpcfg  [PMP_ENTRIES],
  output logic [31:0]      pmp_pmpaddr [PMP_ENTRIES],
`ifdef RV_SMEPMP_MSECCFG_EN
  output el2_mseccfg_pkt_t mseccfg,
`endif
  output logic             pmp_cfg_changed
);

  localparam int NumEntries = int'(PMP_ENTRIES);
  // Low address bits forced to 1 (NAPOT) or 0 (OFF/TOR) on readback for coarse granules.
  localparam logic [31:0] NapotOnes =
      (PMP_GRANULARITY >= 2) ? ((32'd1 << (PMP_GRANULARITY - 1)) - 32'd1) : 32'd0;
  localparam logic [31:0] OffMask =
      (PMP_GRANULARITY >= 1) ? ((32'd1 << PMP_GRANULARITY) - 32'd1) : 32'd0;

  el2_pmp_cfg_pkt_t cfg_q  [PMP_ENTRIES];
  el2_pmp_cfg_pkt_t cfg_d  [PMP_ENTRIES];
  logic [31:0]      addr_q [PMP_ENTRIES];
  logic [31:0]      addr_d [PMP_ENTRIES];
  logic [PMP_ENTRIES-1:0] addr_lock;
  logic             changed_q, changed_d;
  logic             rd_valid_q, rd_hit_q;
  logic [31:0]      rd_data_q;
  logic             rd_hit;
  logic [31:0]      rd_data;
  logic             any_lock;
  logic             rlb, mml;
  logic             wr_cfg, wr_addr;

  assign wr_cfg  = csr.csr_wr_en && (csr.csr_wr_addr[11:2] == 10'h0E8);
  assign wr_addr = csr.csr_wr_en && (csr.csr_wr_addr[11:4] == 8'h3B);

`ifdef RV_SMEPMP_MSECCFG_EN
  el2_mseccfg_pkt_t msec_q, msec_d;
  logic             wr_msec;

  assign wr_msec = csr.csr_wr_en && (csr.csr_wr_addr == 12'h747);
  assign rlb     = msec_q.rlb;
  assign mml     = msec_q.mml;
  assign mseccfg = msec_q;

  // MML/MMWP are sticky; RLB can only be raised while no entry is locked.
  always_comb begin
    msec_d = msec_q;
    if (wr_msec) begin
      msec_d.mml  = msec_q.mml | csr.csr_wr_data[0];
      msec_d.mmwp = msec_q.mmwp | csr.csr_wr_data[1];
      if (msec_q.rlb || !any_lock) msec_d.rlb = csr.csr_wr_data[2];
    end
  end

  // mseccfg state register.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) msec_q <= '0;
    else        msec_q <= msec_d;
  end
`else
  assign rlb = 1'b0;
  assign mml = 1'b0;
`endif

  // Legalise one written cfg byte against the pre-write entry and security state.
  function automatic el2_pmp_cfg_pkt_t cfg_write(el2_pmp_cfg_pkt_t old, logic [7:0] wdata,
                                                 logic rlb_v, logic mml_v);
    el2_pmp_cfg_pkt_t nw;
    logic             ignore;
    nw          = el2_pmp_cfg_pkt_t'(wdata);
    nw.reserved = 2'b00;
    if (PMP_GRANULARITY >= 1 && nw.mode == ModeNa4) nw.mode = ModeOff;
    ignore = (old.lock && !rlb_v) ||
             (!nw.read && nw.write && !mml_v) ||
             (mml_v && !rlb_v && nw.lock && (nw.execute || (!nw.read && nw.write)));
    return ignore ? old : nw;
  endfunction

  function automatic logic [31:0] addr_rdback(logic [31:0] a, el2_pmp_mode_t mode);
    if (mode == ModeNapot) return a | NapotOnes;
    if (mode == ModeOff || mode == ModeTor) return a & ~OffMask;
    return a;
  endfunction

  // Per-entry lock summary used by address writes and the RLB rule.
  always_comb begin
    any_lock  = 1'b0;
    addr_lock = '0;
    for (int i = 0; i < NumEntries; i++) begin
      any_lock     = any_lock | cfg_q[i].lock;
      addr_lock[i] = cfg_q[i].lock;
      // A locked TOR entry also protects the address of the entry below it.
      if (i + 1 < NumEntries) begin
        addr_lock[i] = addr_lock[i] | (cfg_q[(i + 1) % NumEntries].lock &&
                                       cfg_q[(i + 1) % NumEntries].mode == ModeTor);
      end
      addr_lock[i] = addr_lock[i] && !rlb;
    end
  end

  // Next-state for cfg bytes and address words, plus the change detector.
  always_comb begin
    changed_d = 1'b0;
    for (int i = 0; i < NumEntries; i++) begin
      cfg_d[i]  = cfg_q[i];
      addr_d[i] = addr_q[i];
      if (wr_cfg && csr.csr_wr_addr[1:0] == 2'(i / 4)) begin
        cfg_d[i] = cfg_write(cfg_q[i], csr.csr_wr_data[8*(i%4) +: 8], rlb, mml);
      end
      if (wr_addr && csr.csr_wr_addr[3:0] == 4'(i) && !addr_lock[i]) begin
        addr_d[i] = csr.csr_wr_data;
      end
      if (cfg_d[i] != cfg_q[i] || addr_d[i] != addr_q[i]) changed_d = 1'b1;
    end
`ifdef RV_SMEPMP_MSECCFG_EN
    if (msec_d != msec_q) changed_d = 1'b1;
`endif
  end

  // cfg/addr state and change pulse registers.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < NumEntries; i++) begin
        cfg_q[i]  <= '0;
        addr_q[i] <= '0;
      end
      changed_q <= 1'b0;
    end else begin
      cfg_q     <= cfg_d;
      addr_q    <= addr_d;
      changed_q <= changed_d;
    end
  end

  // Read decode; unimplemented entries inside the window hit but return zero.
  always_comb begin
    rd_hit  = 1'b0;
    rd_data = '0;
    if (csr.csr_rd_addr[11:2] == 10'h0E8) begin
      rd_hit = 1'b1;
      for (int i = 0; i < NumEntries; i++) begin
        if (csr.csr_rd_addr[1:0] == 2'(i / 4)) rd_data[8*(i%4) +: 8] = cfg_q[i];
      end
    end else if (csr.csr_rd_addr[11:4] == 8'h3B) begin
      rd_hit = 1'b1;
      for (int i = 0; i < NumEntries; i++) begin
        if (csr.csr_rd_addr[3:0] == 4'(i)) rd_data = addr_rdback(addr_q[i], cfg_q[i].mode);
      end
    end
`ifdef RV_SMEPMP_MSECCFG_EN
    else if (csr.csr_rd_addr == 12'h747) begin
      rd_hit  = 1'b1;
      rd_data = {29'b0, msec_q};
    end
`endif
  end

  // Registered read response; data is held at zero when no read is issued.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rd_valid_q <= 1'b0;
      rd_hit_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= csr.csr_rd_en;
      rd_hit_q   <= csr.csr_rd_en & rd_hit;
      rd_data_q  <= csr.csr_rd_en ? rd_data : '0;
    end
  end

  assign csr.csr_rd_valid = rd_valid_q;
  assign csr.csr_rd_hit   = rd_hit_q;
  assign csr.csr_rd_data  = rd_data_q;
  assign pmp_pmpcfg       = cfg_q;
  assign pmp_pmpaddr      = addr_q;
  assign pmp_cfg_changed  = changed_q;

endmodule

// File: tb/tb_el2_pmp_csr.sv
// Directed bench for el2_pmp_csr with 12 entries and a 16-byte granule (G=2).
module tb_el2_pmp_csr;
  import el2_pmp_csr_pkg::*;

  localparam int unsigned Entries = 12;
  localparam int unsigned Gran    = 2;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  el2_pmp_csr_if bus ();
  el2_pmp_cfg_pkt_t pmpcfg  [Entries];
  logic [31:0]      pmpaddr [Entries];
`ifdef RV_SMEPMP_MSECCFG_EN
  el2_mseccfg_pkt_t mseccfg;
`endif
  logic changed;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  el2_pmp_csr #(
    .PMP_ENTRIES    (Entries),
    .PMP_GRANULARITY(Gran)
  ) dut (
    .clk            (clk),
    .rst_l          (rst_l),
    .csr            (bus),
    .pmp_pmpcfg     (pmpcfg),
    .pmp_pmpaddr    (pmpaddr),
`ifdef RV_SMEPMP_MSECCFG_EN
    .mseccfg        (mseccfg),
`endif
    .pmp_cfg_changed(changed)
  );

  task automatic do_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.csr_wr_en   = 1'b1;
    bus.csr_wr_addr = a;
    bus.csr_wr_data = d;
    @(negedge clk);
    bus.csr_wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [11:0] a, output logic v, output logic h,
                         output logic [31:0] d);
    @(negedge clk);
    bus.csr_rd_en   = 1'b1;
    bus.csr_rd_addr = a;
    @(negedge clk);
    bus.csr_rd_en = 1'b0;
    v = bus.csr_rd_valid;
    h = bus.csr_rd_hit;
    d = bus.csr_rd_data;
  endtask

  task automatic check_all_zero(input string name);
    logic nz;
    nz = changed | bus.csr_rd_valid | bus.csr_rd_hit | (|bus.csr_rd_data);
    for (int i = 0; i < int'(Entries); i++) nz = nz | (|pmpcfg[i]) | (|pmpaddr[i]);
`ifdef RV_SMEPMP_MSECCFG_EN
    nz = nz | (|mseccfg);
`endif
    checks++;
    if (nz !== 1'b0) begin
      errors++;
      $display("FAIL %s: some output nonzero (cfg0=%h addr0=%h rd=%h), required all 0",
               name, pmpcfg[0], pmpaddr[0], bus.csr_rd_data);
    end
  endtask

  task automatic test_reset();
    bus.csr_wr_en = 1'b0; bus.csr_wr_addr = '0; bus.csr_wr_data = '0;
    bus.csr_rd_en = 1'b0; bus.csr_rd_addr = '0;
    rst_l = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_asserted");
    rst_l = 1'b1;
    @(negedge clk);
    check_all_zero("reset_released");
  endtask

  task automatic test_cfg_rw();
    logic v, h; logic [31:0] d;
    do_write(12'h3A0, 32'h0F0D0B09);
    checks++; if (changed !== 1'b1) begin errors++;
      $display("FAIL cfg_changed_pulse: got %b required 1", changed); end
    checks++; if (pmpcfg[0] !== 8'h09) begin errors++;
      $display("FAIL cfg0_out: got %h required 09", pmpcfg[0]); end
    checks++; if (pmpcfg[3] !== 8'h0F) begin errors++;
      $display("FAIL cfg3_out: got %h required 0F", pmpcfg[3]); end
    @(negedge clk);
    checks++; if (changed !== 1'b0) begin errors++;
      $display("FAIL cfg_changed_single: got %b required 0", changed); end
    do_read(12'h3A0, v, h, d);
    checks++; if ({v, h, d} !== {2'b11, 32'h0F0D0B09}) begin errors++;
      $display("FAIL cfg0_read: got v=%b h=%b d=%h required 1 1 0F0D0B09", v, h, d); end
    do_write(12'h3A1, 32'h6F6F6F6F);
    checks++; if (pmpcfg[4] !== 8'h0F) begin errors++;
      $display("FAIL cfg_rsvd_bits: got %h required 0F", pmpcfg[4]); end
    do_read(12'h3A1, v, h, d);
    checks++; if (d !== 32'h0F0F0F0F) begin errors++;
      $display("FAIL cfg1_read: got %h required 0F0F0F0F", d); end
  endtask

  task automatic test_lock();
    logic v, h; logic [31:0] d;
    do_write(12'h3A0, 32'h0F0D8F09);
    checks++; if (pmpcfg[1] !== 8'h8F) begin errors++;
      $display("FAIL lock_set: got %h required 8F", pmpcfg[1]); end
    do_write(12'h3B0, 32'h00001234);
    checks++; if ({changed, pmpaddr[0]} !== 33'h0) begin errors++;
      $display("FAIL addr0_tor_locked: got chg=%b addr=%h required 0 0", changed, pmpaddr[0]);
    end
    do_write(12'h3B1, 32'h00000055);
    checks++; if (pmpaddr[1] !== 32'h0) begin errors++;
      $display("FAIL addr1_locked: got %h required 0", pmpaddr[1]); end
    do_write(12'h3B2, 32'h00005678);
    checks++; if (pmpaddr[2] !== 32'h5678) begin errors++;
      $display("FAIL addr2_open: got %h required 5678", pmpaddr[2]); end
    do_write(12'h3A0, 32'h00000000);
    do_read(12'h3A0, v, h, d);
    checks++; if (d !== 32'h00008F00) begin errors++;
      $display("FAIL cfg_locked_byte: got %h required 00008F00", d); end
  endtask

  task automatic test_reserved();
    do_write(12'h3A2, 32'h00000200);
    checks++; if ({changed, pmpcfg[9]} !== 9'h0) begin errors++;
      $display("FAIL rw01_ignored: got chg=%b cfg=%h required 0 00", changed, pmpcfg[9]); end
    do_write(12'h3A2, 32'h00000300);
    checks++; if (pmpcfg[9] !== 8'h03) begin errors++;
      $display("FAIL rw11_written: got %h required 03", pmpcfg[9]); end
    do_write(12'h3A2, 32'h00000600);
    checks++; if (pmpcfg[9] !== 8'h03) begin errors++;
      $display("FAIL xw_r0_ignored: got %h required 03", pmpcfg[9]); end
  endtask

  task automatic test_granularity();
    logic v, h; logic [31:0] d;
    do_write(12'h3B3, 32'h00000100);
    do_write(12'h3A0, 32'h19008F00);
    checks++; if (pmpcfg[3] !== 8'h19) begin errors++;
      $display("FAIL napot_cfg: got %h required 19", pmpcfg[3]); end
    do_read(12'h3B3, v, h, d);
    checks++; if (d !== 32'h101) begin errors++;
      $display("FAIL napot_read: got %h required 101", d); end
    do_write(12'h3A0, 32'h09008F00);
    do_read(12'h3B3, v, h, d);
    checks++; if (d !== 32'h100) begin errors++;
      $display("FAIL tor_read: got %h required 100", d); end
    do_write(12'h3B3, 32'h00000103);
    checks++; if (pmpaddr[3] !== 32'h103) begin errors++;
      $display("FAIL addr_full_store: got %h required 103", pmpaddr[3]); end
    do_read(12'h3B3, v, h, d);
    checks++; if (d !== 32'h100) begin errors++;
      $display("FAIL tor_mask_read: got %h required 100", d); end
    do_write(12'h3A0, 32'h11008F00);
    checks++; if (pmpcfg[3] !== 8'h01) begin errors++;
      $display("FAIL na4_to_off: got %h required 01", pmpcfg[3]); end
    do_read(12'h3B3, v, h, d);
    checks++; if (d !== 32'h100) begin errors++;
      $display("FAIL off_read: got %h required 100", d); end
  endtask

  task automatic test_window();
    logic v, h; logic [31:0] d;
    do_write(12'h3A3, 32'h0F0F0F0F);
    checks++; if (changed !== 1'b0) begin errors++;
      $display("FAIL unimpl_cfg_write: got chg=%b required 0", changed); end
    do_read(12'h3A3, v, h, d);
    checks++; if ({v, h, d} !== {2'b11, 32'h0}) begin errors++;
      $display("FAIL unimpl_cfg_read: got v=%b h=%b d=%h required 1 1 0", v, h, d); end
    do_write(12'h3BC, 32'h0000DEA0);
    do_read(12'h3BC, v, h, d);
    checks++; if ({v, h, d} !== {2'b11, 32'h0}) begin errors++;
      $display("FAIL unimpl_addr_read: got v=%b h=%b d=%h required 1 1 0", v, h, d); end
    do_read(12'h300, v, h, d);
    checks++; if ({v, h, d} !== {2'b10, 32'h0}) begin errors++;
      $display("FAIL miss_read: got v=%b h=%b d=%h required 1 0 0", v, h, d); end
    do_read(12'h3A4, v, h, d);
    checks++; if (h !== 1'b0) begin errors++;
      $display("FAIL miss_3a4: got h=%b required 0", h); end
    @(negedge clk);
    checks++; if (bus.csr_rd_valid !== 1'b0) begin errors++;
      $display("FAIL idle_valid: got %b required 0", bus.csr_rd_valid); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.csr_wr_en = 1'b1; bus.csr_wr_addr = 12'h3B8; bus.csr_wr_data = 32'h10;
    @(negedge clk);
    checks++; if ({changed, pmpaddr[8]} !== {1'b1, 32'h10}) begin errors++;
      $display("FAIL b2b_first: got chg=%b addr8=%h required 1 10", changed, pmpaddr[8]); end
    bus.csr_wr_addr = 12'h3B9; bus.csr_wr_data = 32'h20;
    @(negedge clk);
    checks++; if (pmpaddr[9] !== 32'h20) begin errors++;
      $display("FAIL b2b_second: got %h required 20", pmpaddr[9]); end
    bus.csr_wr_addr = 12'h3B8; bus.csr_wr_data = 32'hAA;
    bus.csr_rd_en = 1'b1; bus.csr_rd_addr = 12'h3B8;
    @(negedge clk);
    bus.csr_wr_en = 1'b0; bus.csr_rd_en = 1'b0;
    checks++; if ({bus.csr_rd_valid, bus.csr_rd_data} !== {1'b1, 32'h10}) begin errors++;
      $display("FAIL rd_wr_same: got v=%b d=%h required 1 10", bus.csr_rd_valid,
               bus.csr_rd_data); end
    checks++; if (pmpaddr[8] !== 32'hAA) begin errors++;
      $display("FAIL b2b_third: got %h required AA", pmpaddr[8]); end
  endtask

  task automatic test_mseccfg();
    logic v, h; logic [31:0] d;
`ifdef RV_SMEPMP_MSECCFG_EN
    do_write(12'h747, 32'h3);
    do_write(12'h747, 32'h0);
    checks++; if (mseccfg !== 3'b011) begin errors++;
      $display("FAIL msec_sticky: got %b required 011", mseccfg); end
    do_write(12'h747, 32'h4);
    checks++; if (mseccfg !== 3'b011) begin errors++;
      $display("FAIL rlb_blocked: got %b required 011", mseccfg); end
    do_read(12'h747, v, h, d);
    checks++; if ({h, d} !== {1'b1, 32'h3}) begin errors++;
      $display("FAIL msec_read: got h=%b d=%h required 1 3", h, d); end
    do_write(12'h3A2, 32'h00020300);
    checks++; if (pmpcfg[10] !== 8'h02) begin errors++;
      $display("FAIL mml_rw01: got %h required 02", pmpcfg[10]); end
    do_write(12'h3A2, 32'h85020300);
    checks++; if (pmpcfg[11] !== 8'h00) begin errors++;
      $display("FAIL mml_locked_x: got %h required 00", pmpcfg[11]); end
`else
    do_write(12'h747, 32'h3);
    checks++; if (changed !== 1'b0) begin errors++;
      $display("FAIL msec_absent_write: got chg=%b required 0", changed); end
    do_read(12'h747, v, h, d);
    checks++; if ({v, h, d} !== {2'b10, 32'h0}) begin errors++;
      $display("FAIL msec_absent_read: got v=%b h=%b d=%h required 1 0 0", v, h, d); end
`endif
  endtask

  task automatic test_reset_mid();
    logic v, h; logic [31:0] d;
    @(negedge clk);
    bus.csr_rd_en = 1'b1; bus.csr_rd_addr = 12'h3A1;
    @(posedge clk);
    #1;
    bus.csr_rd_en = 1'b0;
    rst_l = 1'b0;
    #1;
    check_all_zero("reset_mid_read");
    @(negedge clk);
    rst_l = 1'b1;
    do_read(12'h3A1, v, h, d);
    checks++; if ({v, h, d} !== {2'b11, 32'h0}) begin errors++;
      $display("FAIL post_reset_read: got v=%b h=%b d=%h required 1 1 0", v, h, d); end
  endtask

  initial begin
    test_reset();
    test_cfg_rw();
    test_lock();
    test_reserved();
    test_granularity();
    test_window();
    test_back_to_back();
    test_mseccfg();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
